// File: rtl/conv_loop_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_loop_scheduler_if : layer-control / datapath bundle for the scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
interface conv_loop_scheduler_if #(
  parameter int KW = 4,
  parameter int CW = 8,
  parameter int SW = 8
);
  logic          start;
  logic          abort;
  logic [KW-1:0] cfg_k;
  logic [CW-1:0] cfg_c;
  logic [SW-1:0] cfg_w;
  logic [SW-1:0] cfg_h;
  logic          stop;
  logic          valid;
  logic [KW-1:0] kx;
  logic [KW-1:0] ky;
  logic [CW-1:0] ci;
  logic [SW-1:0] ox;
  logic [SW-1:0] oy;
  logic          acc_first;
  logic          acc_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, abort, cfg_k, cfg_c, cfg_w, cfg_h, stop,
    output valid, kx, ky, ci, ox, oy, acc_first, acc_last, busy, done
  );

  modport slave (
    output start, abort, cfg_k, cfg_c, cfg_w, cfg_h, stop,
    input  valid, kx, ky, ci, ox, oy, acc_first, acc_last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/conv_loop_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_loop_scheduler : nested (kx,ky,ci,ox,oy) tuple generator for one layer
// Revision 1.0
// ---------------------------------------------------------------------------
module conv_loop_scheduler #(
  parameter int KW = 4,
  parameter int CW = 8,
  parameter int SW = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  conv_loop_scheduler_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic [KW-1:0] r_cfg_k, w_cfg_k;
  logic [CW-1:0] r_cfg_c, w_cfg_c;
  logic [SW-1:0] r_cfg_w, w_cfg_w;
  logic [SW-1:0] r_cfg_h, w_cfg_h;
  logic [KW-1:0] r_kx, w_kx, r_ky, w_ky;
  logic [CW-1:0] r_ci, w_ci;
  logic [SW-1:0] r_ox, w_ox, r_oy, w_oy;
  logic          r_valid, w_valid;
  logic          r_acc_first, w_acc_first;
  logic          r_acc_last, w_acc_last;
  logic          r_busy, w_busy;
  logic          r_done, w_done;

  // Terminal values are config-1 in each config's own width, so 2^N-1 is legal.
  logic w_kx_end, w_ky_end, w_ci_end, w_ox_end, w_oy_end, w_last, w_cfg_zero;
  assign w_kx_end   = (r_kx == r_cfg_k - KW'(1));
  assign w_ky_end   = (r_ky == r_cfg_k - KW'(1));
  assign w_ci_end   = (r_ci == r_cfg_c - CW'(1));
  assign w_ox_end   = (r_ox == r_cfg_w - SW'(1));
  assign w_oy_end   = (r_oy == r_cfg_h - SW'(1));
  assign w_last     = w_kx_end && w_ky_end && w_ci_end && w_ox_end && w_oy_end;
  assign w_cfg_zero = (bus.cfg_k == '0) || (bus.cfg_c == '0) ||
                      (bus.cfg_w == '0) || (bus.cfg_h == '0);

  always_comb begin
    w_state = r_state;
    w_cfg_k = r_cfg_k;
    w_cfg_c = r_cfg_c;
    w_cfg_w = r_cfg_w;
    w_cfg_h = r_cfg_h;
    w_kx    = r_kx;
    w_ky    = r_ky;
    w_ci    = r_ci;
    w_ox    = r_ox;
    w_oy    = r_oy;
    w_valid = r_valid;
    w_busy  = r_busy;
    w_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_valid = 1'b0;
        w_busy  = 1'b0;
        if (bus.start) begin
          w_cfg_k = bus.cfg_k;
          w_cfg_c = bus.cfg_c;
          w_cfg_w = bus.cfg_w;
          w_cfg_h = bus.cfg_h;
          w_kx    = '0;
          w_ky    = '0;
          w_ci    = '0;
          w_ox    = '0;
          w_oy    = '0;
          w_busy  = 1'b1;
          if (w_cfg_zero) begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end else begin
            w_state = S_RUN;
            w_valid = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          w_state = S_DONE;
          w_valid = 1'b0;
          w_done  = 1'b1;
        end else if (r_valid && !bus.stop) begin
          // Full carry chain resolves in one cycle, innermost loop first.
          w_kx = w_kx_end ? '0 : r_kx + KW'(1);
          if (w_kx_end) begin
            w_ky = w_ky_end ? '0 : r_ky + KW'(1);
            if (w_ky_end) begin
              w_ci = w_ci_end ? '0 : r_ci + CW'(1);
              if (w_ci_end) begin
                w_ox = w_ox_end ? '0 : r_ox + SW'(1);
                if (w_ox_end) begin
                  w_oy = w_oy_end ? '0 : r_oy + SW'(1);
                end
              end
            end
          end
          if (w_last) begin
            w_state = S_DONE;
            w_valid = 1'b0;
            w_done  = 1'b1;
          end
        end
      end

      S_DONE: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
        w_busy  = 1'b0;
        w_kx    = '0;
        w_ky    = '0;
        w_ci    = '0;
        w_ox    = '0;
        w_oy    = '0;
      end

      default: begin
        w_state = S_IDLE;
        w_valid = 1'b0;
        w_busy  = 1'b0;
      end
    endcase

    // Framing flags follow the next tuple, so they also hold naturally under stop.
    w_acc_first = w_valid && (w_kx == '0) && (w_ky == '0) && (w_ci == '0);
    w_acc_last  = w_valid && (w_kx == w_cfg_k - KW'(1)) &&
                  (w_ky == w_cfg_k - KW'(1)) && (w_ci == w_cfg_c - CW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cfg_k     <= '0;
      r_cfg_c     <= '0;
      r_cfg_w     <= '0;
      r_cfg_h     <= '0;
      r_kx        <= '0;
      r_ky        <= '0;
      r_ci        <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_valid     <= 1'b0;
      r_acc_first <= 1'b0;
      r_acc_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cfg_k     <= w_cfg_k;
      r_cfg_c     <= w_cfg_c;
      r_cfg_w     <= w_cfg_w;
      r_cfg_h     <= w_cfg_h;
      r_kx        <= w_kx;
      r_ky        <= w_ky;
      r_ci        <= w_ci;
      r_ox        <= w_ox;
      r_oy        <= w_oy;
      r_valid     <= w_valid;
      r_acc_first <= w_acc_first;
      r_acc_last  <= w_acc_last;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign bus.valid     = r_valid;
  assign bus.kx        = r_kx;
  assign bus.ky        = r_ky;
  assign bus.ci        = r_ci;
  assign bus.ox        = r_ox;
  assign bus.oy        = r_oy;
  assign bus.acc_first = r_acc_first;
  assign bus.acc_last  = r_acc_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_loop_scheduler.sv
`default_nettype none
// Scoreboard bench for conv_loop_scheduler: a flat-index loop model feeds a queue
// that a negedge monitor drains on every consumed tuple.
module tb_conv_loop_scheduler;
  localparam int KW = 4;
  localparam int CW = 8;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  conv_loop_scheduler_if #(.KW(KW), .CW(CW), .SW(SW)) bus ();

  conv_loop_scheduler #(.KW(KW), .CW(CW), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kx; int ky; int ci; int ox; int oy; bit af; bit al;
  } tup_t;

  tup_t exp_q[$];
  tup_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cons = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: tuple t of the pass decomposed by mixed-radix division.
  task automatic model_pass(input int k, input int c, input int w, input int h);
    int n, kk, pix;
    tup_t t;
    kk  = k * k;
    pix = kk * c;
    n   = pix * w * h;
    for (int i = 0; i < n; i++) begin
      t.kx = i % k;
      t.ky = (i / k) % k;
      t.ci = (i / kk) % c;
      t.ox = (i / pix) % w;
      t.oy = i / (pix * w);
      t.af = ((i % pix) == 0);
      t.al = ((i % pix) == pix - 1);
      exp_q.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.valid && !bus.stop && !bus.abort) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL extra_tuple: actual=(%0d,%0d,%0d,%0d,%0d) required=none",
                 bus.kx, bus.ky, bus.ci, bus.ox, bus.oy);
      end else begin
        m_e = exp_q.pop_front();
        if (int'(bus.kx) != m_e.kx || int'(bus.ky) != m_e.ky || int'(bus.ci) != m_e.ci ||
            int'(bus.ox) != m_e.ox || int'(bus.oy) != m_e.oy ||
            bus.acc_first != m_e.af || bus.acc_last != m_e.al) begin
          errors++;
          $display("FAIL tuple%0d: actual=(%0d,%0d,%0d,%0d,%0d f%0d l%0d) required=(%0d,%0d,%0d,%0d,%0d f%0d l%0d)",
                   cons + 1, bus.kx, bus.ky, bus.ci, bus.ox, bus.oy, bus.acc_first, bus.acc_last,
                   m_e.kx, m_e.ky, m_e.ci, m_e.ox, m_e.oy, m_e.af, m_e.al);
        end
        cons++;
      end
    end else if (!reset && !bus.valid) begin
      checks++;
      if (bus.acc_first || bus.acc_last) begin
        errors++;
        $display("FAIL idle_flags: actual=%0d%0d required=00", bus.acc_first, bus.acc_last);
      end
    end
  end

  function automatic longint outs_vec();
    return longint'({bus.valid, bus.acc_first, bus.acc_last, bus.busy, bus.done,
                     bus.kx, bus.ky, bus.ci, bus.ox, bus.oy});
  endfunction

  task automatic do_pass(input int k, input int c, input int w, input int h,
                         input int stop_lo, input int stop_hi, input int stop_pct,
                         input int abort_at, input bit abort_stop, input int reset_at);
    int n, cyc, stalls, budget;
    n = k * k * c * w * h;
    model_pass(k, c, w, h);
    cons = 0;
    bus.stop  = 1'b0;
    bus.cfg_k = KW'(k);
    bus.cfg_c = CW'(c);
    bus.cfg_w = SW'(w);
    bus.cfg_h = SW'(h);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.cfg_k = KW'($urandom);
    bus.cfg_c = CW'($urandom);
    bus.cfg_w = SW'($urandom);
    bus.cfg_h = SW'($urandom);
    cyc = 1;
    stalls = 0;
    budget = 4 * n + 20;
    while (!bus.done) begin
      if (cyc > budget) begin
        chk("done_timeout", cyc, budget);
        exp_q.delete();
        return;
      end
      if (abort_at > 0 && bus.valid && cons + 1 == abort_at) begin
        bus.abort = 1'b1;
        bus.stop  = abort_stop;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.stop  = 1'b0;
        chk("abort_done_valid", {bus.done, bus.valid}, 2'b10);
        chk("abort_remaining", exp_q.size(), n - abort_at + 1);
        exp_q.delete();
        @(posedge clk); #1;
        chk("abort_idle", {bus.done, bus.busy}, 2'b00);
        return;
      end
      if (reset_at > 0 && bus.valid && cons + 1 == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midpass_reset_outs", outs_vec(), 0);
        chk("reset_remaining", exp_q.size(), n - reset_at + 1);
        exp_q.delete();
        @(posedge clk); #1;
        chk("reset_no_done", {bus.done, bus.busy, bus.valid}, 3'b000);
        return;
      end
      bus.stop = (cyc >= stop_lo && cyc <= stop_hi) || (int'($urandom_range(99)) < stop_pct);
      if (bus.valid && bus.stop) stalls++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.stop = 1'b0;
    chk("done_cycle", cyc, n + 1 + stalls);
    chk("tuples_left", exp_q.size(), 0);
    chk("done_state", {bus.valid, bus.busy}, 2'b01);
    exp_q.delete();
    @(posedge clk); #1;
    chk("post_done", {bus.done, bus.busy, bus.valid}, 3'b000);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stop  = 1'b0;
    bus.cfg_k = '0;
    bus.cfg_c = '0;
    bus.cfg_w = '0;
    bus.cfg_h = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_outs", outs_vec(), 0);

    do_pass(3, 2, 2, 2, 0, -1, 0, 0, 1'b0, 0);
    do_pass(3, 2, 2, 2, 5, 7, 0, 0, 1'b0, 0);
    do_pass(3, 0, 2, 2, 0, -1, 0, 0, 1'b0, 0);
    do_pass(3, 2, 2, 2, 0, -1, 0, 10, 1'b1, 0);
    do_pass(1, 1, 1, 1, 0, -1, 0, 0, 1'b0, 0);
    do_pass(3, 2, 2, 2, 0, -1, 0, 10, 1'b0, 0);
    do_pass(3, 2, 2, 2, 0, -1, 0, 0, 1'b0, 30);
    do_pass(3, 2, 2, 2, 0, -1, 0, 0, 1'b0, 0);
    do_pass(2, 3, 2, 2, 0, -1, 40, 0, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      do_pass(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
              0, -1, 30, 0, 1'b0, 0);
    end
    do_pass(15, 255, 1, 1, 0, -1, 0, 0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
